// File: rtl/cpu_pkg.sv
// Shared 6502 core types: sequencer states, interrupt sources,
// status register bit positions and default vector addresses.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUMMY,
    S_PUSH_PCH,
    S_PUSH_PCL,
    S_PUSH_P,
    S_VEC_LO,
    S_VEC_HI,
    S_LOAD
  } state_t;

  typedef enum logic [1:0] {
    SRC_NMI,
    SRC_BRK,
    SRC_IRQ
  } src_t;

  localparam int PSR_C = 0;
  localparam int PSR_Z = 1;
  localparam int PSR_I = 2;
  localparam int PSR_D = 3;
  localparam int PSR_B = 4;
  localparam int PSR_V = 6;
  localparam int PSR_N = 7;

  localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;
  localparam logic [15:0] NMI_VEC_DEF    = 16'hFFFA;
  localparam logic [15:0] IRQ_VEC_DEF    = 16'hFFFE;

  // Bit 5 always reads back as 1; B exists only in the pushed copy.
  function automatic logic [7:0] push_p(
    input logic [7:0] psr,
    input logic       brk
  );
    return (psr & 8'hCF) | 8'h20 | ({7'b0, brk} << PSR_B);
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// NMI falling-edge detector with a sticky pending flag.
// req also covers an edge seen in the current cycle.
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n,
  input  logic clear,
  output logic pending,
  output logic req
);

  logic prev;
  logic fall;

  assign fall = prev & ~nmi_n;
  assign req  = pending | fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= 1'b1;
      pending <= 1'b0;
    end else begin
      prev    <= nmi_n;
      pending <= (pending & ~clear) | fall;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 NMI/IRQ/BRK entry sequencer: push PC and P, set I, fetch vector.
// Define NMI_HIJACK_EN to let a late NMI steal a BRK/IRQ vector fetch.
module interrupt_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEF,
  parameter logic [15:0] NMI_VEC    = NMI_VEC_DEF,
  parameter logic [15:0] IRQ_VEC    = IRQ_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  psr_in,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic        brk_req,
  input  logic        instr_boundary,
  input  logic [15:0] pc_in,
  input  logic [7:0]  sp_in,
  input  logic [7:0]  db_in,
  output logic        busy,
  output logic [15:0] addr_out,
  output logic        rd_en,
  output logic        we,
  output logic [7:0]  data_out,
  output logic        sp_dec,
  output logic        set_i,
  output logic        pc_load,
  output logic [15:0] pc_vector
);

  state_t      state;
  src_t        src;
  src_t        sel;
  logic        take;
  logic        irq_ok;
  logic [15:0] pc_push;
  logic [7:0]  sp_lat;
  logic [15:0] vec;
  logic        vec_nmi;
  logic [7:0]  vec_lo;
  logic        hijack;
  logic        nmi_pending;
  logic        nmi_req;
  logic        nmi_clear;

  assign nmi_clear = (state == S_VEC_LO) && vec_nmi;
  assign irq_ok    = ~irq_n & ~psr_in[PSR_I];

  nmi_edge_detect u_nmi (
    .clk     (clk),
    .rst     (rst),
    .nmi_n   (nmi_n),
    .clear   (nmi_clear),
    .pending (nmi_pending),
    .req     (nmi_req)
  );

  always_comb begin
    take = 1'b1;
    sel  = SRC_IRQ;
    if (nmi_req)      sel  = SRC_NMI;
    else if (brk_req) sel  = SRC_BRK;
    else if (irq_ok)  sel  = SRC_IRQ;
    else              take = 1'b0;
  end

  always_comb begin
    hijack = 1'b0;
`ifdef NMI_HIJACK_EN
    hijack = (state == S_PUSH_P) && nmi_req && !vec_nmi;
`else
    hijack = 1'b0;
`endif
  end

  always_comb begin
    data_out  = 8'h00;
    pc_vector = 16'h0000;
    case (state)
      S_PUSH_PCH: data_out  = pc_push[15:8];
      S_PUSH_PCL: data_out  = pc_push[7:0];
      S_PUSH_P:   data_out  = push_p(psr_in, src == SRC_BRK);
      S_LOAD:     pc_vector = {db_in, vec_lo};
      default:    data_out  = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      src      <= SRC_IRQ;
      pc_push  <= '0;
      sp_lat   <= '0;
      vec      <= '0;
      vec_nmi  <= 1'b0;
      vec_lo   <= '0;
      busy     <= 1'b0;
      addr_out <= '0;
      rd_en    <= 1'b0;
      we       <= 1'b0;
      sp_dec   <= 1'b0;
      set_i    <= 1'b0;
      pc_load  <= 1'b0;
    end else begin
      busy     <= 1'b0;
      addr_out <= '0;
      rd_en    <= 1'b0;
      we       <= 1'b0;
      sp_dec   <= 1'b0;
      set_i    <= 1'b0;
      pc_load  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_boundary && take) begin
            state   <= S_DUMMY;
            busy    <= 1'b1;
            src     <= sel;
            pc_push <= (sel == SRC_BRK) ? pc_in + 16'd2 : pc_in;
            sp_lat  <= sp_in;
            vec_nmi <= (sel == SRC_NMI);
            vec     <= (sel == SRC_NMI) ? NMI_VEC : IRQ_VEC;
          end
        end
        S_DUMMY: begin
          state    <= S_PUSH_PCH;
          busy     <= 1'b1;
          addr_out <= {STACK_PAGE, sp_lat};
          we       <= 1'b1;
          sp_dec   <= 1'b1;
        end
        S_PUSH_PCH: begin
          state    <= S_PUSH_PCL;
          busy     <= 1'b1;
          addr_out <= {STACK_PAGE, sp_lat - 8'd1};
          we       <= 1'b1;
          sp_dec   <= 1'b1;
        end
        S_PUSH_PCL: begin
          state    <= S_PUSH_P;
          busy     <= 1'b1;
          addr_out <= {STACK_PAGE, sp_lat - 8'd2};
          we       <= 1'b1;
          sp_dec   <= 1'b1;
        end
        S_PUSH_P: begin
          state    <= S_VEC_LO;
          busy     <= 1'b1;
          rd_en    <= 1'b1;
          set_i    <= 1'b1;
          if (hijack) begin
            vec      <= NMI_VEC;
            vec_nmi  <= 1'b1;
            addr_out <= NMI_VEC;
          end else begin
            addr_out <= vec;
          end
        end
        S_VEC_LO: begin
          state    <= S_VEC_HI;
          busy     <= 1'b1;
          rd_en    <= 1'b1;
          addr_out <= vec + 16'd1;
        end
        S_VEC_HI: begin
          state   <= S_LOAD;
          busy    <= 1'b1;
          pc_load <= 1'b1;
          vec_lo  <= db_in;
        end
        S_LOAD: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: IRQ, mask, BRK, NMI priority,
// NMI hijack (either build) and reset in the middle of a sequence.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  psr_in;
  logic        nmi_n;
  logic        irq_n;
  logic        brk_req;
  logic        instr_boundary;
  logic [15:0] pc_in;
  logic [7:0]  sp_in;
  logic [7:0]  db_in;
  logic        busy;
  logic [15:0] addr_out;
  logic        rd_en;
  logic        we;
  logic [7:0]  data_out;
  logic        sp_dec;
  logic        set_i;
  logic        pc_load;
  logic [15:0] pc_vector;

  int n_chk  = 0;
  int n_pass = 0;

  interrupt_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .psr_in         (psr_in),
    .nmi_n          (nmi_n),
    .irq_n          (irq_n),
    .brk_req        (brk_req),
    .instr_boundary (instr_boundary),
    .pc_in          (pc_in),
    .sp_in          (sp_in),
    .db_in          (db_in),
    .busy           (busy),
    .addr_out       (addr_out),
    .rd_en          (rd_en),
    .we             (we),
    .data_out       (data_out),
    .sp_dec         (sp_dec),
    .set_i          (set_i),
    .pc_load        (pc_load),
    .pc_vector      (pc_vector)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic push_chk(
    input string       tag,
    input logic [15:0] a,
    input logic [7:0]  d
  );
    check({tag, ".addr"}, addr_out, a);
    check({tag, ".data"}, data_out, d);
    check({tag, ".we"}, {we, sp_dec, rd_en}, 3'b110);
  endtask

  // Caller drives the request with instr_boundary=1 in cycle T.
  task automatic seq_check(
    input logic [15:0] a0,
    input logic [7:0]  d0,
    input logic [15:0] a1,
    input logic [7:0]  d1,
    input logic [15:0] a2,
    input logic [7:0]  d2,
    input logic [15:0] v,
    input logic [7:0]  lo,
    input logic [7:0]  hi,
    input logic        nmi3
  );
    tick();
    instr_boundary = 1'b0;
    brk_req        = 1'b0;
    check("t1.busy_we", {busy, we, rd_en}, 3'b100);
    tick();
    push_chk("t2.pch", a0, d0);
    tick();
    push_chk("t3.pcl", a1, d1);
    if (nmi3) nmi_n = 1'b0;
    tick();
    push_chk("t4.p", a2, d2);
    tick();
    check("t5.addr", addr_out, v);
    check("t5.ctl", {rd_en, set_i, we, sp_dec}, 4'b1100);
    tick();
    check("t6.addr", addr_out, v + 16'd1);
    check("t6.ctl", {rd_en, set_i, we}, 3'b100);
    db_in = lo;
    tick();
    db_in = hi;
    #1;
    check("t7.load", {busy, pc_load, rd_en}, 3'b110);
    check("t7.vec", pc_vector, {hi, lo});
    tick();
    check("t8.idle", {busy, pc_load, we}, 3'b000);
    db_in = 8'h00;
  endtask

  task automatic idle_check(input string tag);
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    check({tag, ".busy"}, {busy, we}, 2'b00);
    tick();
    tick();
    check({tag, ".later"}, {busy, we, rd_en}, 3'b000);
  endtask

  initial begin
    rst            = 1'b1;
    psr_in         = 8'h24;
    nmi_n          = 1'b1;
    irq_n          = 1'b1;
    brk_req        = 1'b0;
    instr_boundary = 1'b0;
    pc_in          = 16'h0000;
    sp_in          = 8'hFF;
    db_in          = 8'h00;
    tick();
    tick();
    check("rst.ctl", {busy, rd_en, we, sp_dec, set_i, pc_load}, 6'b0);
    check("rst.bus", {addr_out, data_out}, 24'h0);
    rst = 1'b0;
    tick();

    // IRQ taken
    irq_n = 1'b0; psr_in = 8'h20; pc_in = 16'h1234; sp_in = 8'hFF;
    instr_boundary = 1'b1;
    seq_check(16'h01FF, 8'h12, 16'h01FE, 8'h34, 16'h01FD, 8'h20,
              16'hFFFE, 8'h00, 8'h80, 1'b0);

    // IRQ masked
    psr_in = 8'h24;
    idle_check("irq_masked");
    irq_n = 1'b1;

    // BRK with PC and SP wrap
    brk_req = 1'b1; psr_in = 8'h20; pc_in = 16'hFFFF; sp_in = 8'h01;
    instr_boundary = 1'b1;
    seq_check(16'h0101, 8'h00, 16'h0100, 8'h01, 16'h01FF, 8'h30,
              16'hFFFE, 8'h34, 8'h12, 1'b0);

    // NMI beats IRQ at the same boundary
    nmi_n = 1'b0; irq_n = 1'b0; psr_in = 8'h20;
    pc_in = 16'h4000; sp_in = 8'hFD;
    instr_boundary = 1'b1;
    seq_check(16'h01FD, 8'h40, 16'h01FC, 8'h00, 16'h01FB, 8'h20,
              16'hFFFA, 8'h00, 8'h90, 1'b0);
    psr_in = 8'h24;
    idle_check("nmi_cleared");
    psr_in = 8'h20;
    instr_boundary = 1'b1;
    seq_check(16'h01FD, 8'h40, 16'h01FC, 8'h00, 16'h01FB, 8'h20,
              16'hFFFE, 8'h00, 8'h80, 1'b0);
    irq_n = 1'b1; nmi_n = 1'b1;
    tick();

    // NMI edge during a BRK sequence
    brk_req = 1'b1; psr_in = 8'h20; pc_in = 16'h2000; sp_in = 8'hFF;
    instr_boundary = 1'b1;
`ifdef NMI_HIJACK_EN
    seq_check(16'h01FF, 8'h20, 16'h01FE, 8'h02, 16'h01FD, 8'h30,
              16'hFFFA, 8'h00, 8'hA0, 1'b1);
    idle_check("hijack_cleared");
`else
    seq_check(16'h01FF, 8'h20, 16'h01FE, 8'h02, 16'h01FD, 8'h30,
              16'hFFFE, 8'h00, 8'hA0, 1'b1);
    pc_in = 16'hA000; sp_in = 8'hFC;
    instr_boundary = 1'b1;
    seq_check(16'h01FC, 8'hA0, 16'h01FB, 8'h00, 16'h01FA, 8'h20,
              16'hFFFA, 8'h00, 8'h90, 1'b0);
    idle_check("nmi_late_cleared");
`endif
    nmi_n = 1'b1;
    tick();

    // Reset in the middle of an IRQ push
    irq_n = 1'b0; psr_in = 8'h20; pc_in = 16'h1111; sp_in = 8'hFF;
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    irq_n = 1'b1;
    tick();
    tick();
    check("mid.pre", {busy, we}, 2'b11);
    rst = 1'b1;
    #1;
    check("mid.ctl", {busy, rd_en, we, sp_dec, set_i, pc_load}, 6'b0);
    check("mid.bus", {addr_out, data_out, pc_vector}, 40'h0);
    tick();
    rst = 1'b0;
    tick();
    check("post.idle", {busy, we}, 2'b00);
    idle_check("post.noreq");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
